// File: rtl/rf_scoreboard.sv
// 2-read/1-write register file with an in-order pending-load scoreboard.
// Optional RF_BYPASS_EN: reads and busy flags reflect this cycle's commits.
module rf_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int LD_DEPTH = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               ra1,
    input  logic [ADDR_W-1:0]               ra2,
    output logic [DATA_W-1:0]               rd1,
    output logic [DATA_W-1:0]               rd2,
    output logic                            busy1,
    output logic                            busy2,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               wa,
    input  logic [DATA_W-1:0]               wd,
    input  logic                            res_valid,
    input  logic [ADDR_W-1:0]               res_addr,
    input  logic                            res_half,
    input  logic                            res_hi,
    output logic                            res_ready,
    input  logic                            ld_ack,
    input  logic [DATA_W-1:0]               ld_data,
    output logic [$clog2(LD_DEPTH+1)-1:0]   ld_cnt,
    output logic                            err
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int HALF  = DATA_W / 2;
    localparam int CNT_W = $clog2(LD_DEPTH + 1);
    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              half;
        logic              hi;
    } ld_entry_t;

    logic [DATA_W-1:0] rf [NREGS];
    logic [NREGS-1:0]  busy;
    ld_entry_t         fifo [LD_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    ld_entry_t         head;
    logic              push;
    logic              pop;
    logic              ack_empty;
    logic [DATA_W-1:0] ld_word;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head      = fifo[rd_ptr];
    assign res_ready = (ld_cnt < CNT_W'(LD_DEPTH)) && !busy[res_addr];
    assign push      = res_valid && res_ready;
    assign pop       = ld_ack && (ld_cnt != '0);
    assign ack_empty = ld_ack && (ld_cnt == '0);

    // Halfword loads merge into the currently registered word of the target
    always_comb begin
        ld_word = ld_data;
        if (head.half) begin
            if (head.hi)
                ld_word = {ld_data[HALF-1:0], rf[head.addr][HALF-1:0]};
            else
                ld_word = {rf[head.addr][DATA_W-1:HALF], ld_data[HALF-1:0]};
        end
    end

    // Load completion is assigned last so it wins over an ALU write to the same register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else begin
            if (we && !is_zero(wa))
                rf[wa] <= wd;
            if (pop && !is_zero(head.addr))
                rf[head.addr] <= ld_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ld_cnt <= '0;
            err    <= 1'b0;
            for (int i = 0; i < LD_DEPTH; i++)
                fifo[i] <= '0;
        end else begin
            if (pop) begin
                busy[head.addr] <= 1'b0;
                rd_ptr          <= ptr_inc(rd_ptr);
            end
            if (push) begin
                if (!is_zero(res_addr))
                    busy[res_addr] <= 1'b1;
                fifo[wr_ptr] <= '{addr: res_addr, half: res_half, hi: res_hi};
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            ld_cnt <= ld_cnt + CNT_W'(push) - CNT_W'(pop);
            // A pending load always marks its target busy, so this also flags write/load collisions
            if ((we && !is_zero(wa) && busy[wa]) || ack_empty)
                err <= 1'b1;
        end
    end

`ifdef RF_BYPASS_EN
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = rf[a];
        if (we && wa == a)
            v = wd;
        if (pop && head.addr == a)
            v = ld_word;
        return is_zero(a) ? '0 : v;
    endfunction

    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        return busy[a] && !(pop && head.addr == a) && !is_zero(a);
    endfunction
`else
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        return is_zero(a) ? '0 : rf[a];
    endfunction

    function automatic logic busy_port(input logic [ADDR_W-1:0] a);
        return busy[a] && !is_zero(a);
    endfunction
`endif

    assign rd1   = read_port(ra1);
    assign rd2   = read_port(ra2);
    assign busy1 = busy_port(ra1);
    assign busy2 = busy_port(ra2);

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard (default parameters) against a queue-based model.
// Honours RF_BYPASS_EN when the same macro is defined for the build.
module tb_rf_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0, res_addr = '0;
    logic [DW-1:0] rd1, rd2, wd = '0, ld_data = '0;
    logic          busy1, busy2, we = 1'b0, res_valid = 1'b0, res_half = 1'b0, res_hi = 1'b0;
    logic          res_ready, ld_ack = 1'b0, err;
    logic [CW-1:0] ld_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned a;
        bit          h;
        bit          hi;
    } ent_t;

    logic [DW-1:0] m_rf [16];
    bit            m_busy [16];
    ent_t          m_q [$];
    bit            m_err;

    rf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .LD_DEPTH(DEPTH), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
        .res_valid(res_valid), .res_addr(res_addr), .res_half(res_half), .res_hi(res_hi),
        .res_ready(res_ready), .ld_ack(ld_ack), .ld_data(ld_data), .ld_cnt(ld_cnt), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input ent_t e, input logic [DW-1:0] d);
        if (!e.h) return d;
        if (e.hi) return {d[15:0], old[15:0]};
        return {old[31:16], d[15:0]};
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_rf[a];
`ifdef RF_BYPASS_EN
        if (we && wa == a) v = wd;
        if (ld_ack && m_q.size() > 0 && m_q[0].a == a) v = merge(m_rf[a], m_q[0], ld_data);
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (ld_ack && m_q.size() > 0 && m_q[0].a == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (m_q.size() < DEPTH) && !m_busy[res_addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_q.delete();
        m_err = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock the DUT
    task automatic tick();
        logic [DW-1:0] n_rf [16];
        bit            ready;
        ent_t          e;
        ready = exp_ready();
        for (int i = 0; i < 16; i++) n_rf[i] = m_rf[i];
        if (we && wa != 0) begin
            if (m_busy[wa]) m_err = 1'b1;
            n_rf[wa] = wd;
        end
        if (ld_ack) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                e = m_q.pop_front();
                if (e.a != 0) n_rf[e.a] = merge(m_rf[e.a], e, ld_data);
                m_busy[e.a] = 1'b0;
            end
        end
        if (res_valid && ready) begin
            m_q.push_back('{a: res_addr, h: res_half, hi: res_hi});
            if (res_addr != 0) m_busy[res_addr] = 1'b1;
        end
        for (int i = 0; i < 16; i++) m_rf[i] = n_rf[i];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; res_valid = 0; ld_ack = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ra1 = AW'(i); ra2 = AW'(15 - i);
            #1;
            checks++;
            if (rd1 !== '0 || rd2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read r%0d: rd1=%h rd2=%h busy1=%b busy2=%b, expected zeros", i, rd1, rd2, busy1, busy2);
            end
        end
        checks++;
        if (ld_cnt !== '0 || err !== 1'b0 || res_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: ld_cnt=%0d err=%b res_ready=%b, expected 0 0 1", ld_cnt, err, res_ready);
        end
    endtask

    task automatic test_alu_write();
        we = 1; wa = 3; wd = 32'hDEADBEEF;
        tick();
        idle(); ra1 = 3; #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_write: rd1=%h busy1=%b, expected deadbeef 0", rd1, busy1);
        end
        we = 1; wa = 0; wd = 32'hFFFFFFFF;
        tick();
        idle(); ra2 = 0; #1;
        checks++;
        if (rd2 !== '0) begin
            errors++;
            $display("[TB] FAIL zero_reg_write: rd2=%h, expected 0", rd2);
        end
    endtask

    task automatic test_half_load();
        we = 1; wa = 5; wd = 32'h11112222;
        tick();
        idle(); res_valid = 1; res_addr = 5; res_half = 1; res_hi = 1;
        tick();
        idle(); ra1 = 5; #1;
        checks++;
        if (busy1 !== 1'b1 || ld_cnt !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL half_reserve: busy1=%b ld_cnt=%0d, expected 1 1", busy1, ld_cnt);
        end
        ld_ack = 1; ld_data = 32'h0000ABCD;
        tick();
        idle(); #1;
        checks++;
        if (rd1 !== 32'hABCD2222 || busy1 !== 1'b0 || ld_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL half_hi_load: rd1=%h busy1=%b ld_cnt=%0d, expected abcd2222 0 0", rd1, busy1, ld_cnt);
        end
        res_valid = 1; res_addr = 5; res_half = 1; res_hi = 0;
        tick();
        idle(); ld_ack = 1; ld_data = 32'h9999_1357;
        tick();
        idle(); #1;
        checks++;
        if (rd1 !== 32'hABCD1357) begin
            errors++;
            $display("[TB] FAIL half_lo_load: rd1=%h, expected abcd1357", rd1);
        end
    endtask

    task automatic test_fifo_order();
        res_valid = 1; res_half = 0; res_addr = 1;
        tick();
        res_addr = 2;
        tick();
        idle(); res_addr = 6; #1;
        checks++;
        if (res_ready !== 1'b0 || ld_cnt !== CW'(2)) begin
            errors++;
            $display("[TB] FAIL fifo_full: res_ready=%b ld_cnt=%0d, expected 0 2", res_ready, ld_cnt);
        end
        ld_ack = 1; ld_data = 32'hA;
        tick();
        ld_data = 32'hB;
        tick();
        idle(); ra1 = 1; ra2 = 2; #1;
        checks++;
        if (rd1 !== 32'hA || rd2 !== 32'hB || res_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fifo_order: rd1=%h rd2=%h res_ready=%b, expected a b 1", rd1, rd2, res_ready);
        end
    endtask

    task automatic test_busy_conflict();
        res_valid = 1; res_addr = 4; res_half = 0;
        tick();
        #1;
        checks++;
        if (res_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_block: res_ready=%b, expected 0", res_ready);
        end
        tick();
        idle(); #1;
        checks++;
        if (ld_cnt !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL busy_no_push: ld_cnt=%0d, expected 1", ld_cnt);
        end
        we = 1; wa = 4; wd = 32'h99;
        tick();
        idle(); ra1 = 4; #1;
        checks++;
        if (err !== 1'b1 || rd1 !== 32'h99 || busy1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_busy: err=%b rd1=%h busy1=%b, expected 1 99 1", err, rd1, busy1);
        end
        ld_ack = 1; ld_data = 32'h55;
        tick();
        idle(); #1;
        checks++;
        if (rd1 !== 32'h55) begin
            errors++;
            $display("[TB] FAIL load_after_conflict: rd1=%h, expected 55", rd1);
        end
    endtask

    task automatic test_ack_empty();
        do_reset();
        we = 1; wa = 9; wd = 32'h1234_5678;
        tick();
        idle(); ld_ack = 1; ld_data = 32'hFFFF_FFFF;
        tick();
        idle(); ra1 = 9; #1;
        checks++;
        if (err !== 1'b1 || rd1 !== 32'h1234_5678 || ld_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL ack_empty: err=%b rd1=%h ld_cnt=%0d, expected 1 12345678 0", err, rd1, ld_cnt);
        end
        do_reset();
        res_valid = 1; res_addr = 6;
        tick();
        res_addr = 7;
        tick();
        idle();
        reset = 1'b1;
        model_reset();
        ra1 = 6; ra2 = 7; #1;
        checks++;
        if (ld_cnt !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: ld_cnt=%0d busy1=%b busy2=%b err=%b, expected 0 0 0 0", ld_cnt, busy1, busy2, err);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ld_ack = 1; ld_data = 32'h77;
        tick();
        idle(); #1;
        checks++;
        if (err !== 1'b1 || rd1 !== '0) begin
            errors++;
            $display("[TB] FAIL ack_after_reset: err=%b rd1=%h, expected 1 0", err, rd1);
        end
    endtask

    task automatic test_collision();
        do_reset();
        res_valid = 1; res_addr = 8; res_half = 0;
        tick();
        idle(); we = 1; wa = 8; wd = 32'hCAFE; ld_ack = 1; ld_data = 32'hF00D;
        tick();
        idle(); ra1 = 8; #1;
        checks++;
        if (rd1 !== 32'hF00D || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_reg_collision: rd1=%h err=%b, expected f00d 1", rd1, err);
        end
        do_reset();
        res_valid = 1; res_addr = 10;
        tick();
        idle(); we = 1; wa = 11; wd = 32'h1111; ld_ack = 1; ld_data = 32'h2222;
        tick();
        idle(); ra1 = 10; ra2 = 11; #1;
        checks++;
        if (rd1 !== 32'h2222 || rd2 !== 32'h1111 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL diff_reg_collision: rd1=%h rd2=%h err=%b, expected 2222 1111 0", rd1, rd2, err);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        we = 1; wa = 7; wd = 32'h1111;
        tick();
        idle(); we = 1; wa = 7; wd = 32'h1234; ra2 = 7; #1;
`ifdef RF_BYPASS_EN
        want = 32'h1234;
`else
        want = 32'h1111;
`endif
        checks++;
        if (rd2 !== want) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: rd2=%h, expected %h", rd2, want);
        end
        tick();
        idle(); #1;
        checks++;
        if (rd2 !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL bypass_next_cycle: rd2=%h, expected 1234", rd2);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            we        = ($urandom_range(0, 3) == 0);
            wa        = AW'($urandom);
            wd        = DW'($urandom);
            res_valid = ($urandom_range(0, 1) == 1);
            res_addr  = AW'($urandom);
            res_half  = ($urandom_range(0, 1) == 1);
            res_hi    = ($urandom_range(0, 1) == 1);
            ld_ack    = ($urandom_range(0, 2) == 0);
            ld_data   = DW'($urandom);
            ra1       = AW'($urandom);
            ra2       = AW'($urandom);
            #1;
            checks++;
            if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) || busy1 !== exp_busy(ra1) ||
                busy2 !== exp_busy(ra2) || res_ready !== exp_ready() ||
                ld_cnt !== CW'(m_q.size()) || err !== m_err) begin
                errors++;
                if (bad < 10)
                    $display("[TB] FAIL random[%0d]: rd1=%h/%h rd2=%h/%h busy=%b%b/%b%b ready=%b/%b cnt=%0d/%0d err=%b/%b (actual/required)",
                             n, rd1, exp_rd(ra1), rd2, exp_rd(ra2), busy1, busy2, exp_busy(ra1), exp_busy(ra2),
                             res_ready, exp_ready(), ld_cnt, m_q.size(), err, m_err);
                bad++;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_write();
        test_half_load();
        test_fifo_order();
        test_busy_conflict();
        test_ack_empty();
        test_collision();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
Parametrised 2-read/1-write register file with an in-order pending-load scoreboard.
- The ALU writes full words through the write port.
- Load destinations are reserved at issue and written later, on memory ack, as a full word or as a high/low halfword merge.
- Per-read-port busy flags let the pipeline stall on operands whose load has not yet returned.
- Sits between decode (reads, reservations), writeback (ALU writes) and the data-memory interface (load completion).

Parameters:
DATA_W, 32, register width; must be even.
ADDR_W, 4, register address width; NREGS = 2**ADDR_W.
LD_DEPTH, 2, maximum outstanding loads (pending FIFO depth, >=1).
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
ra1  in  ADDR_W  read address, port 1.
ra2  in  ADDR_W  read address, port 2.
rd1  out  DATA_W  read data, port 1.
rd2  out  DATA_W  read data, port 2.
busy1  out  1  register at ra1 has a pending load.
busy2  out  1  register at ra2 has a pending load.
we  in  1  ALU write enable.
wa  in  ADDR_W  ALU write address.
wd  in  DATA_W  ALU write data.
res_valid  in  1  reserve a load destination.
res_addr  in  ADDR_W  load destination register.
res_half  in  1  1 = halfword load.
res_hi  in  1  halfword target: 1 = upper half, 0 = lower half.
res_ready  out  1  reservation can be accepted this cycle.
ld_ack  in  1  memory data valid for the oldest pending load.
ld_data  in  DATA_W  load data; only bits [DATA_W/2-1:0] are used for halfword loads.
ld_cnt  out  clog2(LD_DEPTH+1)  number of outstanding loads.
err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, active-high):
  - All registers 0, all busy bits 0, FIFO empty.
  - ld_cnt=0, err=0, res_ready=1.
  - rd1/rd2 = 0, busy1/busy2 = 0.
  - Assertion mid-operation discards all outstanding loads immediately; a later ld_ack is handled as an ack-on-empty error.
- Reads: combinational.
  - rdN = rf[raN]; forced to 0 when ZERO_REG=1 and raN=0.
  - busyN = busy[raN], forced 0 for register 0 when ZERO_REG=1.
- ALU write: on a posedge with we=1, rf[wa] <= wd, full width. Writes to register 0 are dropped when ZERO_REG=1.
- Reservation:
  - res_ready = (ld_cnt < LD_DEPTH) && !busy[res_addr]. Purely from registered state; a same-cycle ld_ack does not raise it.
  - Accept on posedge with res_valid && res_ready: push {res_addr, res_half, res_hi}, set busy[res_addr], ld_cnt+1.
  - A reservation of register 0 (ZERO_REG=1) is pushed but sets no busy bit.
  - res_valid while res_ready=0: no effect, no error. The requester holds.
- Load completion: on posedge with ld_ack=1 and FIFO non-empty, pop the head and clear busy[head.addr]; ld_cnt-1.
  - Full-word load (half=0): rf[addr] <= ld_data.
  - Halfword load, hi=1: rf[addr][DATA_W-1:DATA_W/2] <= ld_data[DATA_W/2-1:0]; lower half unchanged.
  - Halfword load, hi=0: rf[addr][DATA_W/2-1:0] <= ld_data[DATA_W/2-1:0]; upper half unchanged.
  - Head entry for register 0 (ZERO_REG=1): popped, data discarded.
- Simultaneous events:
  - Accept and ack in the same cycle: push and pop both occur; ld_cnt unchanged.
  - ALU write and load completion to the same register: load data wins; err set.
  - ALU write and load completion to different registers: both written.
- Error conditions (err is sticky until reset):
  - ALU write to a busy register: the write is performed, busy is unchanged, err set.
  - ld_ack with FIFO empty: ignored, err set.
- FIFO: circular, pointers wrap modulo LD_DEPTH; pops in strict issue order.

Optional Feature:
RF_BYPASS_EN.
- Defined:
  - rdN reflects the value that the current cycle's ALU write and/or load completion will commit, with halfword merge applied; load wins on collision.
  - busyN deasserts in the same cycle as the ld_ack that completes that register.
- Undefined: reads and busy flags show registered state only; new values are visible one cycle after the write edge.

Test Plan:
- Reset, then we=1 wa=3 wd=0xDEADBEEF; next cycle ra1=3 -> rd1=0xDEADBEEF, busy1=0. Write wa=0 -> rd with ra=0 stays 0.
- Preload r5=0x11112222; reserve r5 half=1 hi=1 -> busy at ra=5 goes to 1. ld_ack with ld_data=0x0000ABCD -> r5=0xABCD2222, busy=0, ld_cnt=0.
- Reserve r1 then r2 (LD_DEPTH=2) -> res_ready=0, ld_cnt=2. Acks with 0xA then 0xB -> r1=0xA, r2=0xB in order; res_ready returns to 1.
- Reserve r4, then res_valid with res_addr=4 -> res_ready=0, no push. ALU write r4 -> err=1. Ack 0x55 -> r4=0x55.
- ld_ack with FIFO empty -> no register changes, err=1. Reset asserted mid-pending -> ld_cnt=0, all busy=0, err=0 immediately.
- With RF_BYPASS_EN: we=1 wa=7 wd=0x1234 while ra2=7 -> rd2=0x1234 in the same cycle. Without the macro -> old value that cycle, 0x1234 the next.
